// File: rtl/packet_scheduler.sv
// HDMI data-island packet scheduler: audio > ACR > AVI > SPD > null, with InfoFrame anti-starvation.
// Optional SPD InfoFrame support is enabled by defining HDMI_SPD_INFOFRAME_EN.
module packet_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk_pixel,
    input  logic         reset_n,
    input  logic         frame_start,
    input  logic         packet_slot,
    input  logic         aud_req,
    input  logic         acr_req,
    output logic         aud_ack,
    output logic         acr_ack,
    input  logic [23:0]  aud_header,
    input  logic [223:0] aud_sub,
    input  logic [23:0]  acr_header,
    input  logic [223:0] acr_sub,
    input  logic [23:0]  avi_header,
    input  logic [223:0] avi_sub,
`ifdef HDMI_SPD_INFOFRAME_EN
    input  logic [23:0]  spd_header,
    input  logic [223:0] spd_sub,
`endif
    output logic [23:0]  header,
    output logic [223:0] sub,
    output logic [7:0]   packet_type,
    output logic         packet_valid,
    output logic [7:0]   miss_count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic {IDLE, GRANT} state_t;
    typedef enum logic [2:0] {
        SEL_NULL, SEL_AUD, SEL_ACR, SEL_AVI, SEL_SPD
    } sel_t;

    state_t         state_q, state_d;
    sel_t           sel_q, sel_d;
    logic [23:0]    header_q, header_d;
    logic [223:0]   sub_q, sub_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic           avi_due_q, avi_due_d;
    logic           spd_due_q, spd_due_d;
    logic [7:0]     miss_q, miss_d;
    logic           avi_miss, spd_miss;

    // Arbitration choice for the current slot, from state left by the previous grant
    always_comb begin
        sel_d = SEL_NULL;
        if ((starve_q >= LIMIT) && (avi_due_q || spd_due_q))
            sel_d = avi_due_q ? SEL_AVI : SEL_SPD;
        else if (aud_req)
            sel_d = SEL_AUD;
        else if (acr_req)
            sel_d = SEL_ACR;
        else if (avi_due_q)
            sel_d = SEL_AVI;
        else if (spd_due_q)
            sel_d = SEL_SPD;
    end

    always_comb begin
        state_d   = packet_slot ? GRANT : IDLE;
        header_d  = header_q;
        sub_d     = sub_q;
        starve_d  = starve_q;
        avi_due_d = avi_due_q;
        spd_due_d = spd_due_q;
        miss_d    = miss_q;

        if (packet_slot) begin
            unique case (sel_d)
                SEL_AUD: begin
                    header_d = aud_header;
                    sub_d    = aud_sub;
                end
                SEL_ACR: begin
                    header_d = acr_header;
                    sub_d    = acr_sub;
                end
                SEL_AVI: begin
                    header_d = avi_header;
                    sub_d    = avi_sub;
                end
`ifdef HDMI_SPD_INFOFRAME_EN
                SEL_SPD: begin
                    header_d = spd_header;
                    sub_d    = spd_sub;
                end
`endif
                default: begin
                    header_d = '0;
                    sub_d    = '0;
                end
            endcase

            if (sel_d == SEL_AUD || sel_d == SEL_ACR) begin
                if (starve_q != LIMIT)
                    starve_d = starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end

            if (sel_d == SEL_AVI)
                avi_due_d = 1'b0;
            if (sel_d == SEL_SPD)
                spd_due_d = 1'b0;
        end

        // A flag being serviced in this very slot does not count as missed
        avi_miss = avi_due_q && !(packet_slot && sel_d == SEL_AVI);
        spd_miss = spd_due_q && !(packet_slot && sel_d == SEL_SPD);

        if (frame_start) begin
            if ((avi_miss || spd_miss) && miss_q != 8'hFF)
                miss_d = miss_q + 8'd1;
            avi_due_d = 1'b1;
`ifdef HDMI_SPD_INFOFRAME_EN
            spd_due_d = 1'b1;
`endif
        end

`ifndef HDMI_SPD_INFOFRAME_EN
        spd_due_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_q     <= SEL_NULL;
            header_q  <= '0;
            sub_q     <= '0;
            starve_q  <= '0;
            avi_due_q <= 1'b0;
            spd_due_q <= 1'b0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= packet_slot ? sel_d : sel_q;
            header_q  <= header_d;
            sub_q     <= sub_d;
            starve_q  <= starve_d;
            avi_due_q <= avi_due_d;
            spd_due_q <= spd_due_d;
            miss_q    <= miss_d;
        end
    end

    assign header       = header_q;
    assign sub          = sub_q;
    assign packet_type  = header_q[7:0];
    assign packet_valid = (state_q == GRANT);
    assign aud_ack      = (state_q == GRANT) && (sel_q == SEL_AUD);
    assign acr_ack      = (state_q == GRANT) && (sel_q == SEL_ACR);
    assign miss_count   = miss_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Scoreboard bench for packet_scheduler: directed slots push expected packets, a monitor pops them.
// Covers HDMI_SPD_INFOFRAME_EN both defined and undefined.
module tb_packet_scheduler;

    logic         clk_pixel = 1'b0;
    logic         reset_n;
    logic         frame_start, packet_slot, aud_req, acr_req;
    logic         aud_ack, acr_ack;
    logic [23:0]  aud_header, acr_header, avi_header, spd_header;
    logic [223:0] aud_sub, acr_sub, avi_sub, spd_sub;
    logic [23:0]  header;
    logic [223:0] sub;
    logic [7:0]   packet_type, miss_count;
    logic         packet_valid;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [23:0]  h;
        logic [223:0] s;
        logic         aa;
        logic         ca;
    } exp_t;

    exp_t q[$];

    localparam int K_NULL = 0, K_AUD = 1, K_ACR = 2, K_AVI = 3, K_SPD = 4;

    packet_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .packet_slot  (packet_slot),
        .aud_req      (aud_req),
        .acr_req      (acr_req),
        .aud_ack      (aud_ack),
        .acr_ack      (acr_ack),
        .aud_header   (aud_header),
        .aud_sub      (aud_sub),
        .acr_header   (acr_header),
        .acr_sub      (acr_sub),
        .avi_header   (avi_header),
        .avi_sub      (avi_sub),
`ifdef HDMI_SPD_INFOFRAME_EN
        .spd_header   (spd_header),
        .spd_sub      (spd_sub),
`endif
        .header       (header),
        .sub          (sub),
        .packet_type  (packet_type),
        .packet_valid (packet_valid),
        .miss_count   (miss_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    function automatic void chk(string n, logic [223:0] act, logic [223:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        else
            passed++;
    endfunction

    function automatic void expect_pkt(int k);
        exp_t e;
        e.h  = '0;
        e.s  = '0;
        e.aa = 1'b0;
        e.ca = 1'b0;
        case (k)
            K_AUD: begin e.h = 24'h001102; e.s = {7{32'hA0A00001}}; e.aa = 1'b1; end
            K_ACR: begin e.h = 24'h002201; e.s = {7{32'hC0C00002}}; e.ca = 1'b1; end
            K_AVI: begin e.h = 24'h0D0282; e.s = {7{32'hB1B10003}}; end
            K_SPD: begin e.h = 24'h190183; e.s = {7{32'h5D5D0004}}; end
            default: ;
        endcase
        q.push_back(e);
    endfunction

    // Monitor: every valid strobe must match the oldest expected packet
    always @(negedge clk_pixel) begin
        if (reset_n && packet_valid) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_pkt: got header %0h expected none", header);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("header", 224'(header), 224'(e.h));
                chk("sub", sub, e.s);
                chk("packet_type", 224'(packet_type), 224'(e.h[7:0]));
                chk("aud_ack", 224'(aud_ack), 224'(e.aa));
                chk("acr_ack", 224'(acr_ack), 224'(e.ca));
            end
        end else if (aud_ack || acr_ack) begin
            total++;
            $display("FAIL stray_ack: got aud=%0b acr=%0b expected 0/0", aud_ack, acr_ack);
        end
    end

    task automatic cycle(input logic fs, input logic slot);
        frame_start = fs;
        packet_slot = slot;
        @(posedge clk_pixel);
        #1;
        frame_start = 1'b0;
        packet_slot = 1'b0;
    endtask

    task automatic slot_exp(input int k);
        expect_pkt(k);
        cycle(1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_miss;
        reset_n     = 1'b0;
        frame_start = 1'b0;
        packet_slot = 1'b0;
        aud_req     = 1'b0;
        acr_req     = 1'b0;
        aud_header  = 24'h001102;
        acr_header  = 24'h002201;
        avi_header  = 24'h0D0282;
        spd_header  = 24'h190183;
        aud_sub     = {7{32'hA0A00001}};
        acr_sub     = {7{32'hC0C00002}};
        avi_sub     = {7{32'hB1B10003}};
        spd_sub     = {7{32'h5D5D0004}};

        repeat (3) @(posedge clk_pixel);
        @(negedge clk_pixel);
        chk("rst_header", 224'(header), 224'(0));
        chk("rst_sub", sub, 224'(0));
        chk("rst_type", 224'(packet_type), 224'(0));
        chk("rst_valid", 224'(packet_valid), 224'(0));
        chk("rst_acks", 224'({aud_ack, acr_ack}), 224'(0));
        chk("rst_miss", 224'(miss_count), 224'(0));
        @(posedge clk_pixel);
        #1;
        reset_n = 1'b1;

        // Frame start, then AVI, SPD, null on back-to-back slots
        cycle(1'b1, 1'b0);
        slot_exp(K_AVI);
`ifdef HDMI_SPD_INFOFRAME_EN
        slot_exp(K_SPD);
`endif
        slot_exp(K_NULL);
        cycle(1'b0, 1'b0);

        // Audio beats ACR; then ACR alone; null clears starvation count
        aud_req = 1'b1;
        acr_req = 1'b1;
        slot_exp(K_AUD);
        aud_req = 1'b0;
        slot_exp(K_ACR);
        acr_req = 1'b0;
        slot_exp(K_NULL);
        cycle(1'b0, 1'b0);

        // Starvation: four audio grants, then AVI; audio resumes after
        cycle(1'b1, 1'b0);
        aud_req = 1'b1;
        repeat (4) slot_exp(K_AUD);
        slot_exp(K_AVI);
        slot_exp(K_AUD);
        aud_req = 1'b0;
`ifdef HDMI_SPD_INFOFRAME_EN
        slot_exp(K_SPD);
`endif
        slot_exp(K_NULL);
        cycle(1'b0, 1'b0);
        @(negedge clk_pixel);
        chk("miss_after_starve", 224'(miss_count), 224'(0));

        // frame_start coinciding with an AVI grant keeps avi_due set
        cycle(1'b1, 1'b0);
        expect_pkt(K_AVI);
        cycle(1'b1, 1'b1);
        slot_exp(K_AVI);
`ifdef HDMI_SPD_INFOFRAME_EN
        slot_exp(K_SPD);
        exp_miss = 1;
`else
        exp_miss = 0;
`endif
        slot_exp(K_NULL);
        cycle(1'b0, 1'b0);
        @(negedge clk_pixel);
        chk("miss_coincide", 224'(miss_count), 224'(exp_miss));

        // Reset in the cycle after a slot drops the grant
        @(posedge clk_pixel);
        #1;
        aud_req = 1'b1;
        cycle(1'b0, 1'b1);
        reset_n = 1'b0;
        @(negedge clk_pixel);
        chk("midrst_valid", 224'(packet_valid), 224'(0));
        chk("midrst_aud_ack", 224'(aud_ack), 224'(0));
        chk("midrst_miss", 224'(miss_count), 224'(0));
        @(posedge clk_pixel);
        #1;
        reset_n = 1'b1;
        cycle(1'b0, 1'b0);
        slot_exp(K_AUD);
        aud_req = 1'b0;
        cycle(1'b0, 1'b0);

        // 300 frames with no slots: miss_count = min(frames-1, 255)
        for (int k = 1; k <= 300; k++) begin
            cycle(1'b1, 1'b0);
            @(negedge clk_pixel);
            chk($sformatf("miss_f%0d", k), 224'(miss_count),
                224'((k - 1) > 255 ? 255 : (k - 1)));
        end

        repeat (3) @(posedge clk_pixel);
        #1;
        chk("queue_drained", 224'(q.size()), 224'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
